// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared types and constants for the instruction fetch slice.
//             Provides the fetch state encoding, the sequential PC step, the
//             default reset PC and the canonical NOP used for flushes.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

    // Output-register occupancy. HALT is only reachable when the
    // out-of-range fetch check is compiled in.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    localparam int unsigned  PC_STEP          = 4;
    localparam logic [31:0]  DEFAULT_RESET_PC = 32'h0000_0000;

    // addi x0, x0, 0
    localparam logic [31:0]  INSTR_NOP        = 32'h0000_0013;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_reg
//  Purpose  : Program counter register. Resets to RESET_PC, loads a redirect
//             target with the byte offset forced to zero, or steps to the
//             next sequential word. Arithmetic wraps modulo 2^PC_WIDTH.
//  Ports    : clk        - clock
//             rst        - synchronous active-high reset
//             incr_i     - advance pc by one word
//             load_i     - load load_pc_i (has priority over incr_i)
//             load_pc_i  - redirect target, bits [1:0] ignored
//             pc_o       - current pc
//  Revision : 1.0  initial release
// ============================================================================
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned           PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                incr_i,
    input  logic                load_i,
    input  logic [PC_WIDTH-1:0] load_pc_i,
    output logic [PC_WIDTH-1:0] pc_o
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = {load_pc_i[PC_WIDTH-1:2], 2'b00};
        end else if (incr_i) begin
            pc_d = pc_q + PC_WIDTH'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= {RESET_PC[PC_WIDTH-1:2], 2'b00};
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule : fetch_pc_reg
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : Instruction fetch unit. Addresses an asynchronous word ROM from
//             the pc register, captures the returned instruction together with
//             its pc into a one-entry valid/ready output register, absorbs
//             decode back-pressure and handles redirects (1 bubble).
//  Config   : FETCH_RANGE_CHECK_EN - when defined, a fetch from a pc beyond
//             the ROM halts the unit and raises fault until a redirect.
//             When undefined, upper pc bits are ignored (ROM aliases) and
//             fault is tied low.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             rom_addr / rom_instr     - ROM word address / read data
//             redirect_valid/_pc       - load a new pc (top priority)
//             out_valid/ready/instr/pc - output handshake to decode
//             fault                    - out-of-range fetch halt
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 11,
    parameter int unsigned           PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = PC_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_instr,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic                  fault
);

    fetch_state_e          state_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_instr_q;
    logic [PC_WIDTH-1:0]   out_pc_q;

    logic [PC_WIDTH-1:0]   w_pc;
    logic                  w_load;
    logic                  w_pc_oob;
    logic                  w_fetch;
    logic                  w_trap;

    // The output slot can take a new word when it is empty or being drained
    // this cycle. HALT never loads; only a redirect or reset leaves it.
    assign w_load  = !redirect_valid &&
                     ((state_q == EMPTY) || ((state_q == FULL) && out_ready));
    assign w_fetch = w_load && !w_pc_oob;
    assign w_trap  = w_load &&  w_pc_oob;

`ifdef FETCH_RANGE_CHECK_EN
    generate
        if (PC_WIDTH > ADDR_WIDTH + 2) begin : g_range_chk
            assign w_pc_oob = |w_pc[PC_WIDTH-1:ADDR_WIDTH+2];
        end else begin : g_range_full
            assign w_pc_oob = 1'b0;
        end
    endgenerate
    assign fault = (state_q == HALT);
`else
    assign w_pc_oob = 1'b0;
    assign fault    = 1'b0;
`endif

    fetch_pc_reg #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .incr_i    (w_fetch),
        .load_i    (redirect_valid),
        .load_pc_i (redirect_pc),
        .pc_o      (w_pc)
    );

    // ROM address comes straight off the pc register: no input-to-output path.
    assign rom_addr = w_pc[ADDR_WIDTH+1:2];

    // Redirect wins over everything except reset. A word sitting in the slot
    // with out_ready high during a redirect was already taken by decode, so
    // dropping out_valid here loses nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else if (redirect_valid) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
        end else if (w_fetch) begin
            state_q     <= FULL;
            out_valid_q <= 1'b1;
            out_instr_q <= rom_instr;
            out_pc_q    <= w_pc;
        end else if (w_trap) begin
            state_q     <= HALT;
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;

endmodule : instr_fetch
`default_nettype wire
